vector_loader_spi: RTL and testbench

- SPI peripheral that receives a full player/camera vector set from an external host MCU.
- Presents the set to raybox on new_playerX..new_vplaneY with a write_new_position strobe that spans the next frame tick.
- Sits between the board-level SPI pins and raybox's write_new_position/new_* inputs.
- Replaces direct host driving of those inputs with a clock-domain-safe, frame-synchronised load.

---
 rtl/vector_loader_spi_pkg.sv | 17 +
 rtl/vector_loader_spi_if.sv | 22 ++
 rtl/vector_loader_spi_sync_edge.sv | 30 +++
 rtl/vector_loader_spi.sv | 76 +++++++
 tb/tb_vector_loader_spi.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/vector_loader_spi_pkg.sv
// vector_loader_spi_pkg: shared fixed-point widths and the frame layout for the vector loader.
package vector_loader_spi_pkg;
    localparam int FBITS = 24;
    localparam int NVEC = 6;
    localparam int FRAME_BITS = NVEC * FBITS;
    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    typedef logic [FBITS-1:0] fix_t;
    // Field order matches wire order, so the shift register casts directly (playerX MSB first).
    typedef struct packed {
        fix_t px;
        fix_t py;
        fix_t fx;
        fix_t fy;
        fix_t vx;
        fix_t vy;
    } vec_t;
endpackage

// File: rtl/vector_loader_spi_if.sv
// vector_loader_spi_if: SPI pins, frame tick and the raybox-facing vector outputs.
interface vector_loader_spi_if;
    logic sclk;
    logic mosi;
    logic csb;
    logic tick;
    logic write_new_position;
    logic [vector_loader_spi_pkg::FBITS-1:0] new_playerX, new_playerY, new_facingX;
    logic [vector_loader_spi_pkg::FBITS-1:0] new_facingY, new_vplaneX, new_vplaneY;
    logic busy;
    logic [3:0] err_count;
    modport master (
        output sclk, mosi, csb, tick,
        input write_new_position, new_playerX, new_playerY, new_facingX,
        input new_facingY, new_vplaneX, new_vplaneY, busy, err_count
    );
    modport slave (
        input sclk, mosi, csb, tick,
        output write_new_position, new_playerX, new_playerY, new_facingX,
        output new_facingY, new_vplaneX, new_vplaneY, busy, err_count
    );
endinterface

// File: rtl/vector_loader_spi_sync_edge.sv
// vector_loader_spi_sync_edge: multi-flop synchroniser with registered edge pulses aligned to the synced level.
module vector_loader_spi_sync_edge #(
    parameter int STAGES = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic rise_q, fall_q;
    // Edges are taken from the last two stages so each pulse coincides with the new synced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            rise_q <= sync_q[STAGES-2] & ~sync_q[STAGES-1];
            fall_q <= ~sync_q[STAGES-2] & sync_q[STAGES-1];
        end
    end
    assign q_o = sync_q[STAGES-1];
    assign rise_o = rise_q;
    assign fall_o = fall_q;
endmodule

// File: rtl/vector_loader_spi.sv
// vector_loader_spi: SPI receiver for a six-value player/camera set, handed to raybox
// through a shadow register so new_* only change off the frame tick.
module vector_loader_spi
    import vector_loader_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic reset_n,
    vector_loader_spi_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_OVR = CNT_W'(FRAME_BITS + 1);
    logic sclk_rise, mosi_s, csb_s, csb_rise, csb_fall;
    logic sclk_s_unused, sclk_fall_unused, mosi_rise_unused, mosi_fall_unused;
    logic [FRAME_BITS-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    vec_t shadow_q, shadow_d, out_q, out_d;
    logic pend_q, pend_d, wnp_q, wnp_d;
    logic [3:0] err_q, err_d;
    logic done, bad, xfer, sample;
    vector_loader_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(reset_n), .d_i(bus.sclk),
        .q_o(sclk_s_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused)
    );
    vector_loader_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(reset_n), .d_i(bus.mosi),
        .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );
    vector_loader_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csb (
        .clk(clk), .rst_n(reset_n), .d_i(bus.csb),
        .q_o(csb_s), .rise_o(csb_rise), .fall_o(csb_fall)
    );
    always_comb begin
        sample = sclk_rise && !csb_s;
        done = csb_rise && cnt_q == CNT_FULL;
        bad = csb_rise && cnt_q != CNT_FULL;
        xfer = pend_q && !bus.tick;
        sh_d = sample ? {sh_q[FRAME_BITS-2:0], mosi_s} : sh_q;
        cnt_d = csb_fall ? '0 : (sample && cnt_q != CNT_OVR) ? cnt_q + CNT_W'(1) : cnt_q;
        shadow_d = done ? vec_t'(sh_q) : shadow_q;
        // A completion in the same cycle as a transfer re-arms pend for the newer shadow.
        pend_d = done || (pend_q && !xfer);
        out_d = xfer ? shadow_q : out_q;
        wnp_d = xfer || (wnp_q && !bus.tick);
        err_d = (bad && err_q != 4'hF) ? err_q + 4'd1 : err_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_q <= '0;
            cnt_q <= '0;
            shadow_q <= '0;
            out_q <= '0;
            pend_q <= 1'b0;
            wnp_q <= 1'b0;
            err_q <= '0;
        end else begin
            sh_q <= sh_d;
            cnt_q <= cnt_d;
            shadow_q <= shadow_d;
            out_q <= out_d;
            pend_q <= pend_d;
            wnp_q <= wnp_d;
            err_q <= err_d;
        end
    end
    assign bus.new_playerX = out_q.px;
    assign bus.new_playerY = out_q.py;
    assign bus.new_facingX = out_q.fx;
    assign bus.new_facingY = out_q.fy;
    assign bus.new_vplaneX = out_q.vx;
    assign bus.new_vplaneY = out_q.vy;
    assign bus.write_new_position = wnp_q;
    assign bus.busy = !csb_s;
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_vector_loader_spi.sv
// tb_vector_loader_spi: directed SPI frames against a latest-wins scoreboard sampled at each frame tick.
module tb_vector_loader_spi;
    logic clk = 1'b0;
    logic reset_n;
    int checks = 0;
    int errors = 0;
    logic [143:0] exp_q[$];
    vector_loader_spi_if bus();
    vector_loader_spi #(.SYNC_STAGES(2)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    localparam logic [143:0] F1 = {24'h001800, 24'h00D800, 24'h000000, 24'hFFF000, 24'h000800, 24'h000000};
    localparam logic [143:0] VA = {24'h123456, 24'h654321, 24'hABCDEF, 24'h0F0F0F, 24'hF0F0F0, 24'h5A5A5A};
    localparam logic [143:0] VB = {24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555, 24'h666666};
    localparam logic [143:0] VC = {24'hC00001, 24'h800002, 24'h400003, 24'h000004, 24'hFFFFFF, 24'h7FFFFF};
    localparam logic [143:0] VD = {24'h0A0B0C, 24'h0D0E0F, 24'h102030, 24'h405060, 24'h708090, 24'hA0B0C0};
    function automatic logic [159:0] obs();
        return {16'h0, bus.new_playerX, bus.new_playerY, bus.new_facingX,
                bus.new_facingY, bus.new_vplaneX, bus.new_vplaneY};
    endfunction
    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask
    task automatic spi_bits(input logic [159:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            bus.mosi = d[n-1-i];
            repeat (4) @(negedge clk);
            bus.sclk = 1'b1;
            repeat (4) @(negedge clk);
            bus.sclk = 1'b0;
        end
    endtask
    // Sends n bits, raises csb, optionally pulses tick on cycle tick_k; lat = first cycle strobe seen high.
    task automatic spi_send(input logic [159:0] d, input int n, input int tick_k,
                            output int lat, output logic [159:0] held);
        @(negedge clk) bus.csb = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_low_csb", bus.busy, 1);
        spi_bits(d, n);
        repeat (4) @(negedge clk);
        bus.csb = 1'b1;
        bus.tick = (tick_k == 1);
        lat = 0;
        held = '0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.write_new_position && lat == 0) lat = k;
            if (k == tick_k) held = obs();
            @(negedge clk) bus.tick = (k + 1 == tick_k);
        end
    endtask
    task automatic tick_sample();
        logic [143:0] v;
        @(negedge clk) bus.tick = 1'b1;
        chk("sb_nonempty", exp_q.size() != 0, 1);
        v = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        chk("tick_vec", obs(), {16'h0, v});
        chk("tick_wnp", bus.write_new_position, 1);
        @(negedge clk) bus.tick = 1'b0;
        chk("post_tick_wnp", bus.write_new_position, 0);
        chk("post_tick_vec", obs(), {16'h0, v});
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int lat;
        logic [159:0] held, snap;
        reset_n = 1'b0;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        bus.csb = 1'b1;
        bus.tick = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_vec", obs(), 0);
        chk("rst_wnp", bus.write_new_position, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err_count, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back(F1);
        spi_send({16'h0, F1}, 144, 0, lat, held);
        chk("f1_latency", lat, 4);
        chk("f1_vec", obs(), {16'h0, F1});
        chk("f1_err", bus.err_count, 0);
        repeat (20) @(negedge clk);
        chk("f1_wnp_hold", bus.write_new_position, 1);
        tick_sample();
        spi_send(160'h1234, 143, 0, lat, held);
        chk("short_no_strobe", lat, 0);
        spi_send(160'h5678, 145, 0, lat, held);
        chk("long_no_strobe", lat, 0);
        chk("bad_vec_kept", obs(), {16'h0, F1});
        chk("bad_err2", bus.err_count, 2);
        for (int i = 0; i < 18; i++) spi_send(160'h3FF, 10, 0, lat, held);
        chk("err_sat", bus.err_count, 15);
        chk("err_sat_wnp", bus.write_new_position, 0);
        exp_q.push_back(VA);
        spi_send({16'h0, VA}, 144, 0, lat, held);
        chk("a_latency", lat, 4);
        chk("a_vec", obs(), {16'h0, VA});
        exp_q[exp_q.size()-1] = VB;
        spi_send({16'h0, VB}, 144, 0, lat, held);
        chk("b_vec", obs(), {16'h0, VB});
        chk("b_wnp", bus.write_new_position, 1);
        tick_sample();
        chk("ab_sb_drained", exp_q.size(), 0);
        exp_q.push_back(VC);
        spi_send({16'h0, VC}, 144, 4, lat, held);
        chk("c_stable_on_tick", held, {16'h0, VB});
        chk("c_deferred_latency", lat, 5);
        chk("c_vec", obs(), {16'h0, VC});
        repeat (30) @(negedge clk);
        chk("c_wnp_hold", bus.write_new_position, 1);
        tick_sample();
        chk("err_still_sat", bus.err_count, 15);
        @(negedge clk) bus.csb = 1'b0;
        repeat (4) @(negedge clk);
        spi_bits({16'h0, VD}, 70);
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_vec", obs(), 0);
        chk("async_rst_wnp", bus.write_new_position, 0);
        chk("async_rst_err", bus.err_count, 0);
        chk("async_rst_busy", bus.busy, 0);
        bus.csb = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back(VD);
        spi_send({16'h0, VD}, 144, 0, lat, held);
        chk("d_latency", lat, 4);
        chk("d_err", bus.err_count, 0);
        tick_sample();
        snap = obs();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            bus.sclk = ~bus.sclk;
            bus.mosi = 1'($urandom_range(0, 1));
        end
        repeat (6) @(negedge clk);
        chk("idle_sclk_vec", obs(), snap);
        chk("idle_sclk_busy", bus.busy, 0);
        chk("idle_sclk_wnp", bus.write_new_position, 0);
        chk("idle_sclk_err", bus.err_count, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
